fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-002 Parameter QDEPTH, default 2: fetch queue entries; also the outstanding-request limit.
REQ-003 Port clk, input, 1: the only clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port stall_f, input, 1: hold the presented instruction; no pop.
REQ-006 Port pc_src, input, 1, with btgt, input, 32: taken-branch redirect and its target.
REQ-007 Port jump, input, 1, with jtgt, input, 32: jump redirect and its target.
REQ-008 Port j_src, input, 1, with jrtgt, input, 32: register-jump redirect and its target.
REQ-009 Port imem_req, output, 1: request valid.
REQ-010 Port imem_addr, output, 32: word-aligned fetch address.
REQ-011 Port imem_ready, input, 1: request accepted when imem_req and imem_ready are both high.
REQ-012 Port imem_rvalid, input, 1, with imem_rdata, input, 32: in-order response.
REQ-013 Port instr, output, 32: head instruction; 32'h0 (NOP) when not valid.
REQ-014 Port pc_plus4, output, 32: head PC + 4; 0 when not valid.
REQ-015 Port instr_valid, output, 1: head entry present.

Function
REQ-016 Redirect = j_src | jump | pc_src; target priority: jrtgt, then jtgt, then btgt.
REQ-017 imem_addr = fetch PC register (fpc); fpc advances by 4 (mod 2^32) on each accepted request.
REQ-018 imem_req high only in state FETCH, with no redirect this cycle, and outstanding + occupancy - pop < QDEPTH. pop = instr_valid & ~stall_f.
REQ-019 Each non-discarded imem_rvalid pushes {pc, imem_rdata} into the queue; the entry becomes visible at the head the next cycle (minimum 2-cycle request-to-output latency).
REQ-020 The queue pops on pop; push and pop in the same cycle is legal at any occupancy.
REQ-021 On redirect: fpc <= target; queue flushed; discard <= outstanding after this cycle's accept and response; state <= DRAIN if discard > 0, else FETCH.
REQ-022 This cycle's imem_rvalid during redirect is dropped; this cycle's accepted request is counted in discard.
REQ-023 State DRAIN: each imem_rvalid decrements discard and is not pushed; return to FETCH the cycle after discard reaches 0; imem_req stays low in DRAIN.
REQ-024 A redirect during DRAIN reloads fpc and keeps accumulating discard; nothing is pushed.
REQ-025 Redirect overrides stall_f: outputs go invalid the next cycle regardless of stall.
REQ-026 imem_rvalid with zero outstanding is a protocol error: ignored, with a non-synthesis $display.
REQ-027 The 32-bit PC addition wraps silently; imem_addr[1:0] is always 2'b00.

Reset
REQ-028 On rst: fpc = RESET_PC; queue empty; outstanding = 0; discard = 0; state = FETCH; imem_req = 0; instr_valid = 0; instr = 0; pc_plus4 = 0.
REQ-029 rst mid-transaction abandons all in-flight responses. The bench holds imem quiescent during reset; the first request is issued the cycle after rst deasserts.

Structure
REQ-030 The shared package mips_pkg holds: fetch state enum {FETCH, DRAIN}; NOP constant 32'h0; default RESET_PC.
REQ-031 The queue is a sub-module fetch_fifo (parameter width/depth; push, pop, flush; count output). fetch_unit instantiates it once at 64 bits.

Verification
REQ-032 Zero-wait memory (ready = 1, rvalid 1 cycle after accept), RESET_PC = 0 -> addresses 0, 4, 8 issued on consecutive cycles; pc_plus4 = 4, 8, C on consecutive valid cycles from cycle 2.
REQ-033 stall_f held 3 cycles with the queue full -> imem_req low; instr/pc_plus4 unchanged; no request issued beyond 2 in flight plus queued.
REQ-034 pc_src with btgt = 32'h40 while 2 requests are outstanding -> both responses dropped; next imem_addr = 32'h40; first valid pc_plus4 = 32'h44.
REQ-035 j_src and pc_src in the same cycle (jrtgt = 32'h100, btgt = 32'h40) -> fetch resumes at 32'h100.
REQ-036 Second redirect (jtgt = 32'h200) during DRAIN -> all stale responses discarded; first valid pc_plus4 = 32'h204.
REQ-037 rst asserted mid-fetch -> next cycle instr_valid = 0 and imem_req = 0; the cycle after release, imem_addr = RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  localparam logic [XLEN-1:0] NOP              = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One fetch-queue entry: the PC of the word followed by the word itself.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular queue with flush; push and pop may coincide at any occupancy.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;
  logic             do_push;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop    = pop && (count != '0);
  assign do_push   = push && ((count < CNT_W'(DEPTH)) || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: only entries counted by 'count' are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word requests, queues in-order responses, handles redirects.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        pc_src,
  input  logic [31:0] btgt,
  input  logic        jump,
  input  logic [31:0] jtgt,
  input  logic        j_src,
  input  logic [31:0] jrtgt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        instr_valid
);

  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  fetch_state_e     state, state_n;
  logic [31:0]      fpc, fpc_n;
  logic [31:0]      rpc, rpc_n;
  logic [CNT_W-1:0] outstanding, outstanding_n;
  logic [CNT_W-1:0] discard, discard_n;
  logic             push;

  logic             redirect;
  logic [31:0]      target;
  logic             pop;
  logic             accept;
  logic             rsp;
  logic [SUM_W-1:0] inflight;
  logic [CNT_W-1:0] q_count;
  logic [63:0]      q_head;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;

  assign redirect  = j_src | jump | pc_src;
  assign target    = (j_src ? jrtgt : (jump ? jtgt : btgt)) & ~32'd3;
  assign instr_valid = (q_count != '0);
  assign pop       = instr_valid & ~stall_f;
  assign rsp       = imem_rvalid && (outstanding != '0);
  assign inflight  = SUM_W'(outstanding) + SUM_W'(q_count) - SUM_W'(pop);
  assign imem_req  = !rst && (state == FETCH) && !redirect && (inflight < SUM_W'(QDEPTH));
  assign accept    = imem_req & imem_ready;
  assign imem_addr = fpc;

  assign head       = fetch_entry_t'(q_head);
  assign push_entry = '{pc: rpc, instr: imem_rdata};
  assign instr      = instr_valid ? head.instr : NOP;
  assign pc_plus4   = instr_valid ? head.pc + 32'd4 : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      fpc         <= RESET_PC;
      rpc         <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_n;
      fpc         <= fpc_n;
      rpc         <= rpc_n;
      outstanding <= outstanding_n;
      discard     <= discard_n;
    end
  end

  // Next state; rpc tracks the PC of the next live response.
  always_comb begin
    state_n       = state;
    fpc_n         = fpc;
    rpc_n         = rpc;
    discard_n     = discard;
    push          = 1'b0;
    outstanding_n = outstanding + CNT_W'(accept) - CNT_W'(rsp);
    if (accept) fpc_n = fpc + 32'd4;
    if (redirect) begin
      fpc_n     = target;
      rpc_n     = target;
      discard_n = outstanding_n;
      state_n   = (outstanding_n != '0) ? DRAIN : FETCH;
    end else begin
      unique case (state)
        FETCH: begin
          push = rsp;
          if (rsp) rpc_n = rpc + 32'd4;
        end
        DRAIN: begin
          if (rsp) discard_n = discard - CNT_W'(1);
          if (discard_n == '0) state_n = FETCH;
        end
        default: state_n = FETCH;
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH(64),
    .DEPTH(QDEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .flush    (redirect),
    .head_data(q_head),
    .count    (q_count)
  );

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && imem_rvalid && (outstanding == '0))
      $display("fetch_unit: stray imem_rvalid with nothing outstanding, ignored");
  end
`endif

endmodule
